// File: rtl/cape_sc_decoder_if.sv
// Bus bundle between the CAPE bitstream generator (master) and the SC->binary decoder (slave).
// Progressive outputs exist only when CAPE_DEC_PROGRESSIVE_EN is defined.
interface cape_sc_decoder_if #(
  parameter int WIDTH      = 4,
  parameter int NUM_INPUTS = 2,
  parameter int LEN_W      = WIDTH * NUM_INPUTS
);
  logic                  in_valid;
  logic                  in_last;
  logic [NUM_INPUTS-1:0] Xs;
  logic                  out_valid;
  logic [WIDTH-1:0]      Bzs [NUM_INPUTS];
  logic [LEN_W:0]        len_out;
  logic                  err;
`ifdef CAPE_DEC_PROGRESSIVE_EN
  logic                  run_valid;
  logic [WIDTH-1:0]      run_Bzs [NUM_INPUTS];
`endif

  modport master (
    output in_valid, in_last, Xs,
    input  out_valid, Bzs, len_out, err
`ifdef CAPE_DEC_PROGRESSIVE_EN
    , input run_valid, run_Bzs
`endif
  );

  modport slave (
    input  in_valid, in_last, Xs,
    output out_valid, Bzs, len_out, err
`ifdef CAPE_DEC_PROGRESSIVE_EN
    , output run_valid, run_Bzs
`endif
  );
endinterface

// File: rtl/cape_sc_decoder.sv
// Stochastic-to-binary decoder: counts ones per SC lane and converts to WIDTH-bit values at stream end.
// Optional progressive estimates at power-of-two lengths via CAPE_DEC_PROGRESSIVE_EN.
module cape_sc_decoder #(
  parameter int WIDTH      = 4,
  parameter int NUM_INPUTS = 2,
  parameter int LEN_W      = WIDTH * NUM_INPUTS
) (
  input logic               clk,
  input logic               rst,
  cape_sc_decoder_if.slave  bus
);

  typedef enum logic {IDLE, ACC} state_t;

  localparam logic [LEN_W:0] MAX_LEN = (LEN_W+1)'(1) << LEN_W;

  state_t           state_q, state_d;
  logic [LEN_W:0]   len_q, len_d, len_next;
  logic [LEN_W:0]   ones_q [NUM_INPUTS];
  logic [LEN_W:0]   ones_d [NUM_INPUTS];
  logic [LEN_W:0]   ones_next [NUM_INPUTS];
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] bzs_q [NUM_INPUTS];
  logic [WIDTH-1:0] bzs_d [NUM_INPUTS];
  logic [LEN_W:0]   len_out_q, len_out_d;
  logic             err_q, err_d;
  logic             term, next_pow2;

  function automatic logic is_pow2(input logic [LEN_W:0] len);
    return (len != '0) && ((len & (len - (LEN_W+1)'(1))) == '0);
  endfunction

  // Scale a ones count to WIDTH bits for a power-of-two length, saturating the all-ones case.
  function automatic logic [WIDTH-1:0] sc_convert(input logic [LEN_W:0] ones,
                                                 input logic [LEN_W:0] len);
    logic [LEN_W+WIDTH:0] scaled;
    int k;
    k = 0;
    for (int j = 0; j <= LEN_W; j++) begin
      if (len == ((LEN_W+1)'(1) << j)) k = j;
    end
    scaled = {{WIDTH{1'b0}}, ones};
    if (k <= WIDTH) scaled = scaled << (WIDTH - k);
    else            scaled = scaled >> (k - WIDTH);
    if (|scaled[LEN_W+WIDTH:WIDTH]) return '1;
    return scaled[WIDTH-1:0];
  endfunction

  always_comb begin
    len_next  = len_q + (LEN_W+1)'(1);
    for (int i = 0; i < NUM_INPUTS; i++) begin
      ones_next[i] = ones_q[i] + {{LEN_W{1'b0}}, bus.Xs[i]};
    end
    next_pow2 = is_pow2(len_next);
    term      = bus.in_valid && (bus.in_last || (len_next == MAX_LEN));
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    ones_d      = ones_q;
    out_valid_d = 1'b0;
    bzs_d       = bzs_q;
    len_out_d   = len_out_q;
    err_d       = err_q;
    if (term) begin
      // Counters clear on the terminating beat so the next cycle can open a new stream.
      state_d     = IDLE;
      len_d       = '0;
      ones_d      = '{default: '0};
      out_valid_d = 1'b1;
      len_out_d   = len_next;
      err_d       = !next_pow2;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        bzs_d[i] = next_pow2 ? sc_convert(ones_next[i], len_next) : '0;
      end
    end else if (bus.in_valid) begin
      state_d = ACC;
      len_d   = len_next;
      ones_d  = ones_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      ones_q      <= '{default: '0};
      out_valid_q <= 1'b0;
      bzs_q       <= '{default: '0};
      len_out_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      ones_q      <= ones_d;
      out_valid_q <= out_valid_d;
      bzs_q       <= bzs_d;
      len_out_q   <= len_out_d;
      err_q       <= err_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.Bzs       = bzs_q;
  assign bus.len_out   = len_out_q;
  assign bus.err       = err_q;

`ifdef CAPE_DEC_PROGRESSIVE_EN
  logic             run_valid_q, run_valid_d;
  logic [WIDTH-1:0] run_bzs_q [NUM_INPUTS];
  logic [WIDTH-1:0] run_bzs_d [NUM_INPUTS];

  always_comb begin
    run_valid_d = 1'b0;
    run_bzs_d   = run_bzs_q;
    if (bus.in_valid && next_pow2) begin
      run_valid_d = 1'b1;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        run_bzs_d[i] = sc_convert(ones_next[i], len_next);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_valid_q <= 1'b0;
      run_bzs_q   <= '{default: '0};
    end else begin
      run_valid_q <= run_valid_d;
      run_bzs_q   <= run_bzs_d;
    end
  end

  assign bus.run_valid = run_valid_q;
  assign bus.run_Bzs   = run_bzs_q;
`endif

endmodule

// File: tb/tb_cape_sc_decoder.sv
// Directed self-checking bench for cape_sc_decoder (WIDTH=4, NUM_INPUTS=2).
// Progressive-output checks are compiled in when CAPE_DEC_PROGRESSIVE_EN is defined.
module tb_cape_sc_decoder;
  localparam int WIDTH = 4;
  localparam int NUM_INPUTS = 2;
  localparam int LEN_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int check_count = 0;
  int pass_count = 0;
  int fail_count = 0;

  cape_sc_decoder_if #(.WIDTH(WIDTH), .NUM_INPUTS(NUM_INPUTS), .LEN_W(LEN_W)) bus ();

  cape_sc_decoder #(.WIDTH(WIDTH), .NUM_INPUTS(NUM_INPUTS), .LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Every out_valid pulse is logged so back-to-back results can be checked later.
  int         ov_count = 0;
  logic [3:0] cap_bz0 [64];
  logic [3:0] cap_bz1 [64];
  logic [8:0] cap_len [64];
  logic       cap_err [64];

  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      cap_bz0[ov_count % 64] = bus.Bzs[0];
      cap_bz1[ov_count % 64] = bus.Bzs[1];
      cap_len[ov_count % 64] = bus.len_out;
      cap_err[ov_count % 64] = bus.err;
      ov_count++;
    end
  end

`ifdef CAPE_DEC_PROGRESSIVE_EN
  int         run_count = 0;
  logic [3:0] run_bz0, run_bz1;
  always @(negedge clk) begin
    if (!rst && bus.run_valid) begin
      run_count++;
      run_bz0 = bus.run_Bzs[0];
      run_bz1 = bus.run_Bzs[1];
    end
  end
`endif

  task automatic drive_beat(input logic v, input logic last, input logic [1:0] x);
    bus.in_valid = v;
    bus.in_last  = last;
    bus.Xs       = x;
    @(posedge clk);
    #1;
  endtask

  // Lane i carries a one on the first ones_i beats; optional idle gap after every beat.
  task automatic send_stream(input int n, input int ones0, input int ones1,
                             input bit last_end, input bit gaps);
    for (int b = 0; b < n; b++) begin
      drive_beat(1'b1, last_end && (b == n - 1), {logic'(b < ones1), logic'(b < ones0)});
      if (gaps && b != n - 1) drive_beat(1'b0, 1'b1, 2'b11);
    end
  endtask

  task automatic check_result(input string name, input int idx, input logic [3:0] e0,
                              input logic [3:0] e1, input logic [8:0] elen, input logic eerr);
    check_count++;
    if (cap_bz0[idx] !== e0) begin
      fail_count++; $display("[TB] FAIL %s Bz0 got %h expected %h", name, cap_bz0[idx], e0);
    end else pass_count++;
    check_count++;
    if (cap_bz1[idx] !== e1) begin
      fail_count++; $display("[TB] FAIL %s Bz1 got %h expected %h", name, cap_bz1[idx], e1);
    end else pass_count++;
    check_count++;
    if (cap_len[idx] !== elen) begin
      fail_count++; $display("[TB] FAIL %s len_out got %0d expected %0d", name, cap_len[idx], elen);
    end else pass_count++;
    check_count++;
    if (cap_err[idx] !== eerr) begin
      fail_count++; $display("[TB] FAIL %s err got %b expected %b", name, cap_err[idx], eerr);
    end else pass_count++;
  endtask

  task automatic check_pulses(input string name, input int base, input int expected);
    check_count++;
    if (ov_count - base !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s out_valid pulses got %0d expected %0d", name, ov_count - base, expected);
    end else pass_count++;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.Xs = 2'b00;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_count++;
    if ({bus.out_valid, bus.err} !== 2'b00) begin
      fail_count++; $display("[TB] FAIL reset valid/err got %b%b expected 00", bus.out_valid, bus.err);
    end else pass_count++;
    check_count++;
    if ({bus.Bzs[1], bus.Bzs[0], bus.len_out} !== 17'd0) begin
      fail_count++; $display("[TB] FAIL reset Bzs/len got %h %h %0d expected 0", bus.Bzs[1], bus.Bzs[0], bus.len_out);
    end else pass_count++;
  endtask

  task automatic test_full_length();
    int base = ov_count;
    send_stream(16, 12, 8, 1'b1, 1'b0);
    drive_beat(1'b0, 1'b0, 2'b00);
    drive_beat(1'b0, 1'b0, 2'b00);
    check_pulses("full", base, 1);
    check_result("full", base % 64, 4'hC, 4'h8, 9'd16, 1'b0);
  endtask

  task automatic test_early_term();
    int base = ov_count;
    send_stream(4, 3, 2, 1'b1, 1'b0);
    drive_beat(1'b0, 1'b0, 2'b00);
    check_pulses("early", base, 1);
    check_result("early", base % 64, 4'hC, 4'h8, 9'd4, 1'b0);
  endtask

  task automatic test_saturation();
    int base = ov_count;
    send_stream(8, 8, 8, 1'b1, 1'b0);
    drive_beat(1'b0, 1'b0, 2'b00);
    check_pulses("sat", base, 1);
    check_result("sat", base % 64, 4'hF, 4'hF, 9'd8, 1'b0);
  endtask

  task automatic test_single_beat();
    int base = ov_count;
    send_stream(1, 1, 0, 1'b1, 1'b0);
    drive_beat(1'b0, 1'b0, 2'b00);
    check_pulses("single", base, 1);
    check_result("single", base % 64, 4'hF, 4'h0, 9'd1, 1'b0);
  endtask

  task automatic test_illegal_gaps();
    int base = ov_count;
    send_stream(12, 5, 7, 1'b1, 1'b1);
    drive_beat(1'b0, 1'b0, 2'b00);
    check_pulses("illegal", base, 1);
    check_result("illegal", base % 64, 4'h0, 4'h0, 9'd12, 1'b1);
  endtask

  task automatic test_back_to_back();
    int base = ov_count;
    send_stream(256, 200, 64, 1'b0, 1'b0);
    send_stream(4, 1, 4, 1'b1, 1'b0);
    drive_beat(1'b0, 1'b0, 2'b00);
    check_pulses("b2b", base, 2);
    check_result("b2b_max", base % 64, 4'd12, 4'd4, 9'd256, 1'b0);
    check_result("b2b_next", (base + 1) % 64, 4'h4, 4'hF, 9'd4, 1'b0);
  endtask

  task automatic test_reset_mid_stream();
    int base = ov_count;
    send_stream(5, 5, 5, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_count++;
    if ({bus.out_valid, bus.Bzs[1], bus.Bzs[0], bus.len_out, bus.err} !== 19'd0) begin
      fail_count++; $display("[TB] FAIL midreset outputs got %b %h %h %0d %b expected 0",
                             bus.out_valid, bus.Bzs[1], bus.Bzs[0], bus.len_out, bus.err);
    end else pass_count++;
    drive_beat(1'b0, 1'b0, 2'b00);
    check_pulses("midreset_abort", base, 0);
`ifdef CAPE_DEC_PROGRESSIVE_EN
    run_count = 0;
`endif
    send_stream(16, 12, 8, 1'b1, 1'b0);
    drive_beat(1'b0, 1'b0, 2'b00);
    check_pulses("midreset", base, 1);
    check_result("midreset", base % 64, 4'hC, 4'h8, 9'd16, 1'b0);
`ifdef CAPE_DEC_PROGRESSIVE_EN
    check_count++;
    if (run_count !== 5) begin
      fail_count++; $display("[TB] FAIL run_valid pulses got %0d expected 5", run_count);
    end else pass_count++;
    check_count++;
    if ({run_bz0, run_bz1} !== 8'hC8) begin
      fail_count++; $display("[TB] FAIL run_Bzs got %h %h expected c 8", run_bz0, run_bz1);
    end else pass_count++;
`endif
  endtask

  initial begin
    test_reset();
    test_full_length();
    test_early_term();
    test_saturation();
    test_single_beat();
    test_illegal_gaps();
    test_back_to_back();
    test_reset_mid_stream();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end
endmodule
